led_event_scheduler: RTL
========================

Name: led_event_scheduler

Overview:
- Sits in front of the LED driver and shares the 8 board LEDs between four event sources:
  - CM error reports
  - UART error reports
  - configuration-change notifications
  - UART receive data (debug only)
- Each source event is latched into a one-deep pending slot.
- A round-robin arbiter grants one event at a time. The granted pattern is shown for a fixed hold time, then the LEDs are blanked for a short gap.
- All inputs are already synchronous to clk; clock-domain crossing is done upstream.

Parameters:
- HOLD_CYCLES, default 16: clk cycles a granted pattern is displayed (legal range 1 to 2^CNT_W-1).
- GAP_CYCLES, default 2: blank cycles after each display. 0 means no GAP state.
- CNT_W, default 24: width of the hold/gap counter.
- IDLE_PATTERN, default 8'h00: LED value while idle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- UART_data_debug_switch  in  1  1 = UART data events enabled
- UART_data  in  8  received byte
- UART_data_valid  in  1  byte strobe (single- or multi-cycle)
- CM_errors  in  4  CM error code
- CM_errors_valid  in  1  CM error strobe
- UART_errors  in  2  UART error flags
- UART_errors_valid  in  1  UART error strobe
- config_notification  in  8  current configuration, level signal
- leds  out  8  LED drive
- led_src  out  2  source currently shown: 0 = CM, 1 = UART error, 2 = config, 3 = UART data
- busy  out  1  1 in SHOW or GAP
- drop_count  out  8  saturating count of overwritten pending events

Behaviour:
- Reset (async, rst=1) clears: all pending flags and data, the round-robin pointer (to 0), cfg_prev (to 8'h00), state (to IDLE), leds (to IDLE_PATTERN), led_src (0), busy (0), drop_count (0).
- Event detection (registered, sampled on rising edge):
  - A valid strobe counts only on its rising edge; a held-high strobe is one event.
  - Config event fires when config_notification != cfg_prev. cfg_prev updates every cycle.
  - UART data events are ignored while UART_data_debug_switch = 0. A 1->0 transition of the switch clears any pending UART-data slot without counting a drop.
- Pending slots, one per source:
  - An event stores its display pattern and sets the slot's flag.
  - Patterns: CM = {4'b1000, CM_errors}; UART error = {6'b010000, UART_errors}; config = config_notification; UART data = UART_data.
  - An event arriving while the slot is already pending overwrites the stored pattern and increments drop_count. drop_count saturates at 8'hFF.
  - An event on a slot in the same cycle that slot is granted: the old pattern goes to display, the new pattern becomes pending, and no drop is counted.
- State machine:
  - IDLE:
    - leds = IDLE_PATTERN, busy = 0.
    - If any flag is set, grant the first set flag at or after the pointer (wrapping 3->0).
    - On grant: clear that flag, load the pattern into leds, set led_src, load the counter with HOLD_CYCLES-1, move the pointer to granted+1 mod 4, go to SHOW.
  - SHOW:
    - Hold leds and led_src; decrement the counter.
    - At 0: go to GAP if GAP_CYCLES > 0 (leds = 8'h00, counter = GAP_CYCLES-1); otherwise go to IDLE.
  - GAP:
    - leds = 8'h00; decrement the counter.
    - At 0: go to IDLE.
  - Exactly HOLD_CYCLES cycles of pattern, then GAP_CYCLES blank cycles, then at least one IDLE cycle before the next grant.
- Latency: a strobe rising at edge n latches at n+1, is granted at edge n+2, and leds show the pattern after edge n+2 when the block is idle.
- Events arriving during SHOW or GAP only affect the pending slots; display is never preempted.
- Reset mid-SHOW: leds return to IDLE_PATTERN immediately (asynchronous), and all pending events are lost.

Test Plan:
- Single CM error, 4'b1101, from idle (HOLD=16, GAP=2):
  - leds = 8'h8D for exactly 16 cycles starting 2 cycles after the strobe, with led_src = 0.
  - Then 2 cycles of 8'h00, then IDLE_PATTERN.
- Four simultaneous strobes: CM 4'hD, UART error 2'b01, config change to 8'h81, UART data 8'hAA with switch = 1, pointer = 0:
  - Display order 8'h8D, 8'h41, 8'h81, 8'hAA; led_src 0, 1, 2, 3; drop_count = 0.
- Round-robin fairness: repeated CM errors during each display plus one UART data byte (switch = 1):
  - Display alternates CM / UART data; UART data is never starved beyond one CM display.
- Overflow: three CM errors (4'h1, 4'h2, 4'h3) while SHOW is busy:
  - drop_count = 2; next display = 8'h83.
  - 300 further overwrites saturate drop_count at 8'hFF.
- Debug switch = 0: UART data 8'hDD and 8'hD1 produce no display.
  - Switch 1 with a byte pending, then the switch drops: the slot clears and drop_count is unchanged.
- Config level held at 8'h81 for 100 cycles: one event only.
  - A change to 8'h8D gives one more event.
  - Assert rst during that SHOW: leds = 8'h00 asynchronously and busy = 0.

Source files
------------

// File: rtl/led_event_scheduler.sv
// rtl/led_event_scheduler.sv - round-robin scheduler sharing 8 board LEDs between four event sources
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   UART_data_debug_switch   1 = UART data bytes are displayable events
//   UART_data/_valid         received byte and its strobe
//   CM_errors/_valid         CM error code and its strobe
//   UART_errors/_valid       UART error flags and their strobe
//   config_notification      current configuration (level; any change is an event)
//   leds                     LED drive
//   led_src                  source being shown (0 CM, 1 UART err, 2 config, 3 UART data)
//   busy                     high while a pattern or its trailing gap is on the LEDs
//   drop_count               saturating count of pending events overwritten before display
module led_event_scheduler #(
    parameter int         HOLD_CYCLES  = 16,
    parameter int         GAP_CYCLES   = 2,
    parameter int         CNT_W        = 24,
    parameter logic [7:0] IDLE_PATTERN = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_data_debug_switch,
    input  logic [7:0] UART_data,
    input  logic       UART_data_valid,
    input  logic [3:0] CM_errors,
    input  logic       CM_errors_valid,
    input  logic [1:0] UART_errors,
    input  logic       UART_errors_valid,
    input  logic [7:0] config_notification,
    output logic [7:0] leds,
    output logic [1:0] led_src,
    output logic       busy,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic             cm_v_q, ue_v_q, ud_v_q, sw_q;
    logic [7:0]       cfg_prev;
    logic [3:0]       pend;
    logic [7:0]       pat [4];

    logic [3:0]       ev;
    logic [7:0]       new_pat [4];
    logic             sw_fall;
    logic             grant_valid, grant_now;
    logic [1:0]       grant_idx, idx;
    logic [3:0]       pend_nxt, drop;
    logic [2:0]       drop_n;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_nxt;

    always_comb begin
        ev[0] = CM_errors_valid & ~cm_v_q;
        ev[1] = UART_errors_valid & ~ue_v_q;
        ev[2] = (config_notification != cfg_prev);
        ev[3] = UART_data_valid & ~ud_v_q & UART_data_debug_switch;
        new_pat[0] = {4'b1000, CM_errors};
        new_pat[1] = {6'b010000, UART_errors};
        new_pat[2] = config_notification;
        new_pat[3] = UART_data;
        sw_fall = sw_q & ~UART_data_debug_switch;
    end

    // Scan from furthest to nearest offset so the first set flag at or after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        idx         = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (pend[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        grant_now = (state == S_IDLE) && grant_valid;
    end

    // A slot granted this cycle hands its old pattern to the display, so a new
    // event on it refills the slot without being a drop.
    always_comb begin
        pend_nxt = pend;
        drop     = 4'b0;
        if (grant_now) pend_nxt[grant_idx] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            drop[s] = ev[s] & pend[s] & ~(grant_now && grant_idx == 2'(s));
            if (ev[s]) pend_nxt[s] = 1'b1;
        end
        if (sw_fall) pend_nxt[3] = 1'b0;
        drop_n   = {2'b0, drop[0]} + {2'b0, drop[1]} + {2'b0, drop[2]} + {2'b0, drop[3]};
        drop_sum = {1'b0, drop_count} + {6'b0, drop_n};
        drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ptr        <= 2'd0;
            cm_v_q     <= 1'b0;
            ue_v_q     <= 1'b0;
            ud_v_q     <= 1'b0;
            sw_q       <= 1'b0;
            cfg_prev   <= 8'h00;
            pend       <= 4'b0;
            for (int s = 0; s < 4; s++) pat[s] <= 8'h00;
            leds       <= IDLE_PATTERN;
            led_src    <= 2'd0;
            busy       <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            cm_v_q     <= CM_errors_valid;
            ue_v_q     <= UART_errors_valid;
            ud_v_q     <= UART_data_valid;
            sw_q       <= UART_data_debug_switch;
            cfg_prev   <= config_notification;
            pend       <= pend_nxt;
            drop_count <= drop_nxt;
            for (int s = 0; s < 4; s++) begin
                if (ev[s]) pat[s] <= new_pat[s];
            end
            case (state)
                S_IDLE: begin
                    leds <= IDLE_PATTERN;
                    busy <= 1'b0;
                    if (grant_valid) begin
                        leds    <= pat[grant_idx];
                        led_src <= grant_idx;
                        cnt     <= CNT_W'(HOLD_CYCLES - 1);
                        ptr     <= grant_idx + 2'd1;
                        busy    <= 1'b1;
                        state   <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            leds  <= 8'h00;
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                            state <= S_GAP;
                        end else begin
                            leds  <= IDLE_PATTERN;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        leds  <= IDLE_PATTERN;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
